// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for load_store_unit: request, response and data-memory port.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
// the sender holds its payload stable while valid is 1 and ready is 0.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        mem_enable;
  logic [7:0]  mem_address;
  logic [7:0]  mem_wdata;
  logic [15:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_error;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, rsp_ready,
    output req_ready, mem_enable, mem_address, mem_wdata, rsp_valid, rsp_data, rsp_error
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, rsp_ready,
    input  req_ready, mem_enable, mem_address, mem_wdata, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ISSUE -> (WAIT) -> RESP.
// Optional macro LSU_BOUNDS_CHECK_EN rejects addresses >= MEM_DEPTH with rsp_error.
module load_store_unit #(
  parameter int READ_LATENCY = 1,
  parameter int MEM_DEPTH    = 33
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [7:0]  addr_q, wdata_q;
  logic [7:0]  mem_addr_q, mem_wdata_q;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        accept;
  logic        oob;
  logic        issue;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign issue  = (state_q == ISSUE);

`ifdef LSU_BOUNDS_CHECK_EN
  assign oob = ({1'b0, bus.req_addr} >= DEPTH9);
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH9;
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // Memory port keeps the last issued address/data once ISSUE ends.
      if (issue) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= wr_q ? wdata_q : 8'h00;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_data_d = 16'h0000;
          if (oob) begin
            state_d     = RESP;
            rsp_error_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            rsp_error_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(READ_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_data_d = bus.mem_rdata;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_enable  = issue && wr_q;
  assign bus.mem_address = issue ? addr_q : mem_addr_q;
  assign bus.mem_wdata   = issue ? (wr_q ? wdata_q : 8'h00) : mem_wdata_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_error   = rsp_error_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: reference memory model, expected-response
// queue with latency, write-strobe queue, and a negedge monitor.
module tb_load_store_unit;
  localparam int L     = 1;
  localparam int DEPTH = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  logic [1:0] dbg_state;

  load_store_unit #(.READ_LATENCY(L), .MEM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] init_word(input int i);
    if (i == 5) return 16'h0000;
    return {8'(i * 7 + 3), 8'(i ^ 'h5A)};
  endfunction

  // ---------------- data memory environment ----------------
  logic [15:0] mem_array [256];
  logic [16:0] rd_pipe [L];
  logic [15:0] noise;
  int          issue_cyc = -10;

  always @(posedge clk) begin
    noise <= 16'($urandom);
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= init_word(i);
    end else if (bus.mem_enable) begin
      mem_array[bus.mem_address][7:0] <= bus.mem_wdata;
    end
    if (rst) begin
      for (int i = 0; i < L; i++) rd_pipe[i] <= '0;
    end else begin
      for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (cyc == issue_cyc) ? {1'b1, mem_array[bus.mem_address]} : 17'h0;
    end
  end

  assign bus.mem_rdata = rd_pipe[L-1][16] ? rd_pipe[L-1][15:0] : noise;

  // ---------------- reference model / scoreboard queues ----------------
  logic [15:0] ref_mem [256];
  logic [16:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] wr_q[$];

  task automatic model(input logic w, input logic [7:0] a, input logic [7:0] d, input int acc);
    logic err;
    err = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
    err = (int'(a) >= DEPTH);
`endif
    if (err) begin
      exp_q.push_back({1'b1, 16'h0000});
      lat_q.push_back(acc + 1);
    end else if (w) begin
      ref_mem[a][7:0] = d;
      exp_q.push_back({1'b0, 16'h0000});
      lat_q.push_back(acc + 2);
      wr_q.push_back({a, d});
    end else begin
      exp_q.push_back({1'b0, ref_mem[a]});
      lat_q.push_back(acc + 2 + L);
      issue_cyc = acc;
    end
  endtask

  // ---------------- driver tasks ----------------
  int ready_mode = 2;  // 0 random, 1 forced low, 2 forced high
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input bit keep_valid);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      fail("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    model(w, a, d, cyc + 1);
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_addr  = 8'($urandom);
      bus.req_wdata = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || wr_q.size() != 0) fail("drain_timeout");
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready",   32'(bus.req_ready),   32'd1);
    check("rst_mem_enable",  32'(bus.mem_enable),  32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata",   32'(bus.mem_wdata),   32'd0);
    check("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
    check("rst_rsp_data",    32'(bus.rsp_data),    32'd0);
    check("rst_rsp_error",   32'(bus.rsp_error),   32'd0);
  endtask

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [16:0] prev_rsp   = '0;
  logic [16:0] e;
  logic [15:0] wexp;
  int          lat_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.mem_enable) begin
          if (wr_q.size() == 0) fail("unexpected_write_strobe");
          else begin
            wexp = wr_q.pop_front();
            check("store_addr", 32'(bus.mem_address), 32'(wexp[15:8]));
            check("store_data", 32'(bus.mem_wdata),   32'(wexp[7:0]));
          end
        end
        if (bus.rsp_valid) begin
          check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
          if (exp_q.size() == 0) fail("unexpected_response");
          else begin
            if (!prev_valid) begin
              lat_exp = lat_q[0];
              check("rsp_latency", 32'(cyc + 1), 32'(lat_exp));
            end
            if (prev_valid && !prev_ready)
              check("rsp_hold", 32'({bus.rsp_error, bus.rsp_data}), 32'(prev_rsp));
            if (bus.rsp_ready) begin
              e = exp_q.pop_front();
              void'(lat_q.pop_front());
              check("rsp_data",  32'(bus.rsp_data),  32'(e[15:0]));
              check("rsp_error", 32'(bus.rsp_error), 32'(e[16]));
            end
          end
        end
        prev_valid = bus.rsp_valid;
        prev_ready = bus.rsp_ready;
        prev_rsp   = {bus.rsp_error, bus.rsp_data};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] a;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // store then load at address 5
    ready_mode = 2;
    send(1'b1, 8'h05, 8'hA5, 1'b0);
    send(1'b0, 8'h05, 8'h00, 1'b0);
    drain();

    // response stalled for 5 cycles
    ready_mode = 1;
    send(1'b0, 8'h07, 8'h00, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) fail("stall_rsp_timeout");
    repeat (5) @(negedge clk);
    ready_mode = 2;
    drain();

    // back-to-back with req_valid held high
    send(1'b1, 8'h10, 8'h3C, 1'b1);
    send(1'b0, 8'h10, 8'hFF, 1'b1);
    send(1'b1, 8'h11, 8'hC3, 1'b0);
    drain();

    // reset pulsed while waiting on a load
    send(1'b0, 8'h05, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    wr_q.delete();
    issue_cyc = -10;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    send(1'b0, 8'h05, 8'h00, 1'b0);
    drain();

    // out-of-range store
    send(1'b1, 8'h40, 8'h77, 1'b0);
    send(1'b0, 8'h40, 8'h00, 1'b0);
    drain();

    // randomized traffic
    ready_mode = 0;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                      : 8'($urandom_range(0, DEPTH - 1));
      send(1'($urandom_range(0, 1)), a, 8'($urandom), (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
